dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
- Sequences MIPS load/store requests from the EX/MEM stage onto the single byte-wide data memory port.
- One byte moves per cycle, big-endian: the byte at the lowest address is the most significant.
- Returns sign- or zero-extended load data and reports misaligned or unsupported requests.
- Sits between the pipeline (req/busy/done stall handshake) and the 8-bit memory array.

Parameters:
- ADDR_W, 8, byte-address width of the memory array (256 bytes).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE or DONE.
- opcode  in  6  MIPS opcode of the access.
- addr  in  32  effective byte address (ALU result).
- wdata  in  32  store data (rt register).
- busy  out  1  high while an accepted request is in flight (XFER and DONE); the pipeline stalls on it.
- done  out  1  one-cycle pulse when the access completes.
- err  out  1  one-cycle pulse when a request is rejected.
- rdata  out  32  extended load result; holds until the next completed load.
- mem_addr  out  ADDR_W  byte address to the memory.
- mem_we  out  1  byte write enable.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  byte read from the memory (combinational read of mem_addr).

Behaviour:
- Supported opcodes and byte counts:
  - lb 100000 (1), lh 100001 (2), lw 100011 (4), lbu 100100 (1), lhu 100101 (2).
  - sb 101000 (1), sh 101001 (2), sw 101011 (4).
- States: IDLE, XFER, DONE.
- Reset (asynchronous, immediate on rst_n low):
  - state goes to IDLE.
  - busy, done, err, mem_we go to 0; mem_addr and mem_wdata go to 0.
  - rdata goes to 0x00000000.
- Accept (IDLE or DONE, req=1 at a rising edge):
  - Rejected if opcode is unsupported, or if halfword addr[0]≠0, or word addr[1:0]≠0.
  - On reject: err=1 for the next cycle, state goes to IDLE, no memory access, busy stays 0.
  - Otherwise: latch opcode, addr[ADDR_W-1:0], wdata; clear byte index; go to XFER.
  - addr bits above ADDR_W are ignored.
- XFER (one cycle per byte, index i = 0..N-1):
  - mem_addr = latched address + i, modulo 2^ADDR_W (wraps 255→0).
  - Stores: mem_we=1; mem_wdata = store byte i, MSB first (sw sends wdata[31:24] first; sh sends [15:8] first; sb sends [7:0]).
  - Loads: mem_we=0; mem_rdata is shifted into an accumulator at each rising edge.
  - After byte N-1, go to DONE.
- All mem_* outputs are driven from registers/state only; there is no combinational path from req or addr.
- DONE (one cycle):
  - done=1, busy=1.
  - Loads: rdata updated at the edge entering DONE. lb/lh sign-extend; lbu/lhu zero-extend.
  - Stores leave rdata unchanged.
  - req at the end of DONE is accepted (back-to-back); otherwise state goes to IDLE.
- Latency: done is high N+1 cycles after the accepting edge (lw/sw 5, lh/sh 3, lb/sb 2).
- req during XFER is ignored; the requester holds req until done.
- Reset mid-store: bytes already written stay in memory; no further writes occur.

Test Plan:
- sw wdata=0x11223344 at addr 0x10, then lw 0x10 → mem writes 0x10=0x11 … 0x13=0x44, one per cycle; done on cycle 5 after each accept; rdata=0x11223344.
- sb 0x80 at 0x20, then lb 0x20 and lbu 0x20 → rdata=0xFFFFFF80, then 0x00000080; each done 2 cycles after accept.
- lh at 0x21 and undefined opcode 0x3F → err pulse 1 cycle after each; mem_we never high; busy stays 0; rdata unchanged.
- sw at 0x40 with req raised again mid-XFER, then req held through DONE with lw 0x40 → the mid-XFER req has no effect; lw is accepted at the DONE edge with no IDLE gap.
- rst_n low after 2 bytes of sw 0xAABBCCDD at 0x50 → mem_we drops immediately; state is IDLE; 0x50=0xAA and 0x51=0xBB written; 0x52/0x53 unchanged.
- Address wrap: sh 0xBEEF at addr 0x1FE with ADDR_W=8 → writes 0xFE=0xBE, 0xFF=0xEF; lhu 0xFE returns 0x0000BEEF.

Source files
------------

// File: rtl/dmem_access_ctrl_if.sv
// Pipeline-side request/stall handshake plus the byte-wide data memory port of dmem_access_ctrl.
// The slave modport is the controller's view; the master modport is the pipeline/memory side.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic [5:0]        opcode;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport slave (
        input  req, opcode, addr, wdata, mem_rdata,
        output busy, done, err, rdata, mem_addr, mem_we, mem_wdata
    );

    modport master (
        output req, opcode, addr, wdata, mem_rdata,
        input  busy, done, err, rdata, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/dmem_access_ctrl.sv
// Sequences MIPS loads/stores onto a byte-wide data memory, one byte per cycle, big-endian,
// returning sign/zero-extended load data and flagging misaligned or unsupported requests.
module dmem_access_ctrl #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_access_ctrl_if.slave bus
);
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t            state;
    logic [5:0]        op_q;
    logic              store_q;
    logic [1:0]        idx_q;
    logic [1:0]        last_q;
    logic [31:0]       sdata_q;
    logic [23:0]       acc_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_we_q;
    logic [7:0]        mem_wdata_q;

    logic              req_ok;
    logic              req_store;
    logic [1:0]        req_last;
    logic [31:0]       req_sdata;
    logic [31:0]       full;
    logic [31:0]       ext;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^bus.addr[31:ADDR_W];

    // Store data is pre-aligned so the first byte to send always sits in bits [31:24].
    always_comb begin
        req_ok    = 1'b1;
        req_store = 1'b0;
        req_last  = 2'd0;
        req_sdata = bus.wdata << 24;
        case (bus.opcode)
            OP_LB, OP_LBU: begin
            end
            OP_LH, OP_LHU: begin
                req_last = 2'd1;
                req_ok   = ~bus.addr[0];
            end
            OP_LW: begin
                req_last = 2'd3;
                req_ok   = (bus.addr[1:0] == 2'b00);
            end
            OP_SB: begin
                req_store = 1'b1;
            end
            OP_SH: begin
                req_store = 1'b1;
                req_last  = 2'd1;
                req_sdata = bus.wdata << 16;
                req_ok    = ~bus.addr[0];
            end
            OP_SW: begin
                req_store = 1'b1;
                req_last  = 2'd3;
                req_sdata = bus.wdata;
                req_ok    = (bus.addr[1:0] == 2'b00);
            end
            default: req_ok = 1'b0;
        endcase
    end

    assign full = {acc_q, bus.mem_rdata};

    always_comb begin
        case (op_q)
            OP_LB:   ext = {{24{full[7]}}, full[7:0]};
            OP_LH:   ext = {{16{full[15]}}, full[15:0]};
            OP_LBU:  ext = {24'd0, full[7:0]};
            OP_LHU:  ext = {16'd0, full[15:0]};
            default: ext = full;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= 6'd0;
            store_q     <= 1'b0;
            idx_q       <= 2'd0;
            last_q      <= 2'd0;
            sdata_q     <= 32'd0;
            acc_q       <= 24'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= 8'd0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                // DONE accepts like IDLE so back-to-back requests need no idle gap.
                IDLE, DONE: begin
                    if (bus.req && req_ok) begin
                        state       <= XFER;
                        busy_q      <= 1'b1;
                        op_q        <= bus.opcode;
                        store_q     <= req_store;
                        last_q      <= req_last;
                        idx_q       <= 2'd0;
                        acc_q       <= 24'd0;
                        mem_addr_q  <= bus.addr[ADDR_W-1:0];
                        mem_we_q    <= req_store;
                        mem_wdata_q <= req_sdata[31:24];
                        sdata_q     <= req_sdata << 8;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        err_q  <= bus.req;
                    end
                end
                XFER: begin
                    acc_q <= full[23:0];
                    if (idx_q == last_q) begin
                        state    <= DONE;
                        done_q   <= 1'b1;
                        mem_we_q <= 1'b0;
                        if (!store_q) begin
                            rdata_q <= ext;
                        end
                    end else begin
                        idx_q       <= idx_q + 2'd1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                        mem_wdata_q <= sdata_q[31:24];
                        sdata_q     <= sdata_q << 8;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy_q   <= 1'b0;
                    mem_we_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Scoreboard bench for dmem_access_ctrl: directed requests push expected responses,
// a negedge monitor pops and compares them against done/err pulses.
module tb_dmem_access_ctrl;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef struct {
        bit          is_err;
        logic [31:0] rdata;
        int          lat;
        int          acc_cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   wr_count = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    chk_t chk_q[$];

    logic [7:0] mem [0:255];
    logic       pre_we = 1'b0;
    logic [7:0] pre_addr = 8'd0;
    logic [7:0] pre_data = 8'd0;

    dmem_access_ctrl_if #(.ADDR_W(8)) bus ();

    dmem_access_ctrl #(.ADDR_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Byte-wide memory with a combinational read; the preload port only lets the bench seed bytes.
    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_count          <= wr_count + 1;
        end else if (pre_we) begin
            mem[pre_addr] <= pre_data;
        end
    end

    assign bus.mem_rdata = mem[bus.mem_addr];

    task automatic compareItem(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // All counting happens here so the counters have a single writer.
    always @(negedge clk) begin
        exp_t e;
        chk_t c;
        while (chk_q.size() > 0) begin
            c = chk_q.pop_front();
            compareItem(c.name, c.act, c.exp);
        end
        if (rst_n && (bus.done || bus.err)) begin
            if (sb.size() == 0) begin
                compareItem("unexpected_response", {30'd0, bus.done, bus.err}, 32'd0);
            end else begin
                e = sb.pop_front();
                compareItem("resp_is_err", {31'd0, bus.err}, {31'd0, e.is_err});
                compareItem("resp_done", {31'd0, bus.done}, {31'd0, ~e.is_err});
                compareItem("resp_rdata", bus.rdata, e.rdata);
                compareItem("resp_latency", 32'(cycle - e.acc_cyc + 1), 32'(e.lat));
                compareItem("resp_busy", {31'd0, bus.busy}, {31'd0, ~e.is_err});
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expectResp(input bit is_err, input logic [31:0] rd, input int lat, input int acc_cyc);
        exp_t e;
        e.is_err  = is_err;
        e.rdata   = rd;
        e.lat     = lat;
        e.acc_cyc = acc_cyc;
        sb.push_back(e);
    endtask

    task automatic waitResp(input string name);
        bit got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = bus.done || bus.err;
        end
        checkOutput(name, {31'd0, got}, 32'd1);
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                                 input bit exp_err, input logic [31:0] exp_rd, input int exp_lat);
        @(negedge clk);
        bus.req    = 1'b1;
        bus.opcode = op;
        bus.addr   = a;
        bus.wdata  = wd;
        expectResp(exp_err, exp_rd, exp_lat, cycle + 1);
        waitResp("response_within_budget");
        bus.req = 1'b0;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    initial begin
        int w0;
        int acc;
        bus.req    = 1'b0;
        bus.opcode = 6'd0;
        bus.addr   = 32'd0;
        bus.wdata  = 32'd0;

        repeat (2) @(negedge clk);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
        checkOutput("reset_err", {31'd0, bus.err}, 32'd0);
        checkOutput("reset_mem_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("reset_mem_addr", {24'd0, bus.mem_addr}, 32'd0);
        checkOutput("reset_mem_wdata", {24'd0, bus.mem_wdata}, 32'd0);
        checkOutput("reset_rdata", bus.rdata, 32'd0);
        rst_n = 1'b1;

        w0 = wr_count;
        applyStimulus(OP_SW, 32'h10, 32'h11223344, 1'b0, 32'h0, 5);
        checkOutput("sw_write_count", 32'(wr_count - w0), 32'd4);
        checkOutput("sw_mem_10", {24'd0, mem[8'h10]}, 32'h11);
        checkOutput("sw_mem_11", {24'd0, mem[8'h11]}, 32'h22);
        checkOutput("sw_mem_12", {24'd0, mem[8'h12]}, 32'h33);
        checkOutput("sw_mem_13", {24'd0, mem[8'h13]}, 32'h44);
        applyStimulus(OP_LW, 32'h10, 32'h0, 1'b0, 32'h11223344, 5);

        applyStimulus(OP_SB, 32'h20, 32'h12345680, 1'b0, 32'h11223344, 2);
        checkOutput("sb_mem_20", {24'd0, mem[8'h20]}, 32'h80);
        applyStimulus(OP_LB, 32'h20, 32'h0, 1'b0, 32'hFFFFFF80, 2);
        applyStimulus(OP_LBU, 32'h20, 32'h0, 1'b0, 32'h00000080, 2);

        w0 = wr_count;
        applyStimulus(OP_LH, 32'h21, 32'h0, 1'b1, 32'h00000080, 1);
        applyStimulus(6'h3F, 32'h20, 32'h0, 1'b1, 32'h00000080, 1);
        applyStimulus(OP_SW, 32'h12, 32'hDEADBEEF, 1'b1, 32'h00000080, 1);
        checkOutput("reject_no_writes", 32'(wr_count - w0), 32'd0);
        checkOutput("reject_mem_12", {24'd0, mem[8'h12]}, 32'h33);

        // sw with a different request raised mid-transfer and held into DONE.
        @(negedge clk);
        bus.req    = 1'b1;
        bus.opcode = OP_SW;
        bus.addr   = 32'h40;
        bus.wdata  = 32'hCAFEF00D;
        acc = cycle + 1;
        expectResp(1'b0, 32'h00000080, 5, acc);
        @(negedge clk);
        bus.req = 1'b0;
        @(negedge clk);
        bus.req    = 1'b1;
        bus.opcode = OP_LW;
        bus.addr   = 32'h40;
        bus.wdata  = 32'h0;
        expectResp(1'b0, 32'hCAFEF00D, 5, acc + 5);
        waitResp("b2b_sw_response");
        @(negedge clk);
        checkOutput("b2b_no_idle_gap", {31'd0, bus.busy}, 32'd1);
        waitResp("b2b_lw_response");
        bus.req = 1'b0;
        checkOutput("b2b_mem_40", {24'd0, mem[8'h40]}, 32'hCA);
        checkOutput("b2b_mem_43", {24'd0, mem[8'h43]}, 32'h0D);

        w0 = wr_count;
        applyStimulus(OP_SH, 32'h1FE, 32'h1234BEEF, 1'b0, 32'hCAFEF00D, 3);
        checkOutput("wrap_write_count", 32'(wr_count - w0), 32'd2);
        checkOutput("wrap_mem_fe", {24'd0, mem[8'hFE]}, 32'hBE);
        checkOutput("wrap_mem_ff", {24'd0, mem[8'hFF]}, 32'hEF);
        applyStimulus(OP_LHU, 32'hFE, 32'h0, 1'b0, 32'h0000BEEF, 3);
        applyStimulus(OP_LH, 32'hFE, 32'h0, 1'b0, 32'hFFFFBEEF, 3);

        preload(8'h50, 8'h00);
        preload(8'h51, 8'h00);
        preload(8'h52, 8'h5A);
        preload(8'h53, 8'h5B);
        w0 = wr_count;
        @(negedge clk);
        bus.req    = 1'b1;
        bus.opcode = OP_SW;
        bus.addr   = 32'h50;
        bus.wdata  = 32'hAABBCCDD;
        repeat (3) @(negedge clk);
        rst_n   = 1'b0;
        bus.req = 1'b0;
        #1;
        checkOutput("rst_mid_mem_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_mid_rdata", bus.rdata, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("rst_mid_write_count", 32'(wr_count - w0), 32'd2);
        checkOutput("rst_mid_mem_50", {24'd0, mem[8'h50]}, 32'hAA);
        checkOutput("rst_mid_mem_51", {24'd0, mem[8'h51]}, 32'hBB);
        checkOutput("rst_mid_mem_52", {24'd0, mem[8'h52]}, 32'h5A);
        checkOutput("rst_mid_mem_53", {24'd0, mem[8'h53]}, 32'h5B);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
